game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
Top-level game sequencer for the bar-dodging game. It owns the run state (idle, play, respawn delay, level-up pause, game over), the life count, the level number and the per-level bar speed. It consumes the collision/score block's hit flag and the player position, and it drives the level input of that block, the freeze/respawn controls of the player mover, and the speed setting of the bar generators.

Parameters:
LIVES_INIT, 3, lives loaded at game start (1..7)
RESPAWN_FRAMES, 60, frame ticks spent in DYING before respawn
LEVELUP_FRAMES, 30, frame ticks spent in LEVEL_UP
GOAL_H, 580, player_h at or above this completes the level
MAX_LEVEL, 15, level saturates here
SPEED_BASE, 1, bar_speed at level 0

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
tick  input  1  one-cycle frame strobe (once per video frame)
start_btn  input  1  debounced start button, level-sensitive
hit  input  1  collision flag from the collision/score block (reset_player)
player_h  input  10  player horizontal position, pixels
level  output  10  current level, fed to the collision/score block
lives  output  3  remaining lives
bar_speed  output  4  bar movement step per frame
freeze  output  1  1 = player movement disabled
respawn  output  1  one-cycle pulse: return player to the start position
game_over  output  1  high while in GAME_OVER
best_level  output  10  highest level reached since reset
state  output  3  encoded state, for debug/HUD: IDLE=0, PLAY=1, DYING=2, LEVEL_UP=3, GAME_OVER=4

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; level=0; lives=LIVES_INIT; bar_speed=SPEED_BASE; freeze=1; respawn=0; game_over=0; best_level=0; timer=0; start and hit edge registers=0.
- Edge detection: start_btn and hit are registered once. start_rise = start_btn & ~start_q. hit_rise = hit & ~hit_q. All decisions use these rising edges.
- All state transitions occur on clk. Outputs are registered, so they change one cycle after the triggering input edge. respawn is high for exactly one cycle, on the cycle the state becomes PLAY.
- IDLE: freeze=1. On start_rise: level=0, lives=LIVES_INIT, bar_speed=SPEED_BASE, go to PLAY, pulse respawn.
- PLAY: freeze=0.
  - On hit_rise with lives==1: lives=0, go to GAME_OVER, and best_level=max(best_level, level).
  - On hit_rise with lives>1: lives-1, timer=RESPAWN_FRAMES, go to DYING.
  - Otherwise, when player_h>=GOAL_H: timer=LEVELUP_FRAMES, level=min(level+1, MAX_LEVEL), go to LEVEL_UP.
  - hit_rise has priority over goal in the same cycle.
  - start_rise is ignored in PLAY.
- DYING: freeze=1. The timer decrements only on tick. When tick arrives with timer==1 (or with timer==0 if RESPAWN_FRAMES=0): go to PLAY and pulse respawn. Hit and start are ignored.
- LEVEL_UP: freeze=1. bar_speed = min(SPEED_BASE + level, 15), computed in 5-bit width and then saturated; it updates on the cycle after level changes. The timer behaves as in DYING. On expiry: go to PLAY and pulse respawn.
- Player position during LEVEL_UP: player_h stays >= GOAL_H until respawn takes effect. The goal check in PLAY is therefore masked for 2 cycles after respawn.
- GAME_OVER: freeze=1, game_over=1. On start_rise: same actions as the start transition from IDLE (reload lives/level/speed, PLAY, respawn). best_level persists.
- Level saturation: at MAX_LEVEL, completing the level still passes through LEVEL_UP, but level does not increment.
- tick coincident with a transition into DYING or LEVEL_UP does not decrement the freshly loaded timer.
- Timer is 8 bits; both FRAMES parameters must be <=255.
- Mid-operation reset returns to IDLE immediately, from any state, with the reset values listed above. A pending respawn pulse is cancelled.

Test Plan:
- Reset release, start_btn held high for 5 cycles -> exactly one respawn pulse; state=1; lives=3; level=0; freeze=0; bar_speed=1.
- In PLAY, hit pulses high for 3 cycles -> lives=2, state=2, freeze=1. After 60 ticks -> state=1 and respawn pulse. Holding hit high the whole time causes no second decrement.
- player_h=585 in PLAY -> state=3, level=1, bar_speed=2. After 30 ticks -> PLAY with respawn. Repeat 16 times -> level stays at 15, bar_speed=15.
- Three hits from a fresh game -> lives=0, state=4, game_over=1, best_level equals the level at the third hit. start_btn -> PLAY, lives=3, level=0, best_level retained.
- hit rising and player_h>=GOAL_H in the same cycle -> DYING taken, level unchanged.
- reset_n pulsed low mid-DYING (asynchronous, between clock edges) -> state=0, lives=3, level=0, freeze=1, respawn=0, all set immediately.

Source files
------------

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_ctrl
// Purpose  : Top-level sequencer for the bar-dodging game. Owns the run state
//            (idle, play, respawn delay, level-up pause, game over), the life
//            count, the level number and the per-level bar speed.
// Ports    : clk, reset_n     - clock, asynchronous active-low reset
//            tick             - one-cycle frame strobe
//            start_btn, hit   - level inputs, acted on at their rising edges
//            player_h         - player horizontal position (pixels)
//            level, lives, bar_speed, best_level - game status outputs
//            freeze, respawn  - player mover controls
//            game_over, state - status / debug outputs
// Revision : 1.0 - initial release
// ============================================================================
module game_ctrl #(
  parameter int LIVES_INIT     = 3,
  parameter int RESPAWN_FRAMES = 60,
  parameter int LEVELUP_FRAMES = 30,
  parameter int GOAL_H         = 580,
  parameter int MAX_LEVEL      = 15,
  parameter int SPEED_BASE     = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       start_btn,
  input  logic       hit,
  input  logic [9:0] player_h,
  output logic [9:0] level,
  output logic [2:0] lives,
  output logic [3:0] bar_speed,
  output logic       freeze,
  output logic       respawn,
  output logic       game_over,
  output logic [9:0] best_level,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_DYING     = 3'd2,
    ST_LEVEL_UP  = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam logic [2:0] c_lives_init  = 3'(LIVES_INIT);
  localparam logic [7:0] c_respawn_frm = 8'(RESPAWN_FRAMES);
  localparam logic [7:0] c_levelup_frm = 8'(LEVELUP_FRAMES);
  localparam logic [9:0] c_goal_h      = 10'(GOAL_H);
  localparam logic [9:0] c_max_level   = 10'(MAX_LEVEL);
  localparam logic [3:0] c_speed_base  = 4'(SPEED_BASE);

  state_t     r_state,     w_state_nx;
  logic [9:0] r_level,     w_level_nx;
  logic [2:0] r_lives,     w_lives_nx;
  logic [3:0] r_bar_speed, w_bar_speed_nx;
  logic       r_freeze,    w_freeze_nx;
  logic       r_respawn,   w_respawn_nx;
  logic       r_game_over, w_game_over_nx;
  logic [9:0] r_best,      w_best_nx;
  logic [7:0] r_timer,     w_timer_nx;
  logic [1:0] r_mask,      w_mask_nx;
  logic       r_start_q;
  logic       r_hit_q;

  logic       w_start_rise;
  logic       w_hit_rise;
  logic       w_goal;
  logic [4:0] w_speed_sum;
  logic [3:0] w_speed_sat;

  assign w_start_rise = start_btn & ~r_start_q;
  assign w_hit_rise   = hit & ~r_hit_q;
  // The player is still parked past the goal line until the respawn reaches
  // the mover, so the goal is ignored while the post-respawn mask runs.
  assign w_goal       = (player_h >= c_goal_h) && (r_mask == 2'd0);

  // Speed sum kept in 5 bits so base + level cannot wrap before saturating.
  assign w_speed_sum  = {1'b0, c_speed_base} + r_level[4:0];
  assign w_speed_sat  = (w_speed_sum > 5'd15) ? 4'd15 : w_speed_sum[3:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_level     <= 10'd0;
      r_lives     <= c_lives_init;
      r_bar_speed <= c_speed_base;
      r_freeze    <= 1'b1;
      r_respawn   <= 1'b0;
      r_game_over <= 1'b0;
      r_best      <= 10'd0;
      r_timer     <= 8'd0;
      r_mask      <= 2'd0;
      r_start_q   <= 1'b0;
      r_hit_q     <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_level     <= w_level_nx;
      r_lives     <= w_lives_nx;
      r_bar_speed <= w_bar_speed_nx;
      r_freeze    <= w_freeze_nx;
      r_respawn   <= w_respawn_nx;
      r_game_over <= w_game_over_nx;
      r_best      <= w_best_nx;
      r_timer     <= w_timer_nx;
      r_mask      <= w_mask_nx;
      r_start_q   <= start_btn;
      r_hit_q     <= hit;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_level_nx     = r_level;
    w_lives_nx     = r_lives;
    w_bar_speed_nx = r_bar_speed;
    w_best_nx      = r_best;
    w_timer_nx     = r_timer;
    w_mask_nx      = r_mask;
    w_respawn_nx   = 1'b0;

    case (r_state)
      ST_IDLE, ST_GAME_OVER: begin
        if (w_start_rise) begin
          w_level_nx     = 10'd0;
          w_lives_nx     = c_lives_init;
          w_bar_speed_nx = c_speed_base;
          w_state_nx     = ST_PLAY;
          w_respawn_nx   = 1'b1;
          w_mask_nx      = 2'd2;
        end
      end

      ST_PLAY: begin
        if (r_mask != 2'd0) begin
          w_mask_nx = r_mask - 2'd1;
        end
        if (w_hit_rise) begin
          if (r_lives <= 3'd1) begin
            w_lives_nx = 3'd0;
            w_state_nx = ST_GAME_OVER;
            w_best_nx  = (r_level > r_best) ? r_level : r_best;
          end else begin
            w_lives_nx = r_lives - 3'd1;
            w_timer_nx = c_respawn_frm;
            w_state_nx = ST_DYING;
          end
        end else if (w_goal) begin
          w_timer_nx = c_levelup_frm;
          if (r_level < c_max_level) begin
            w_level_nx = r_level + 10'd1;
          end
          w_state_nx = ST_LEVEL_UP;
        end
      end

      ST_DYING, ST_LEVEL_UP: begin
        if (r_state == ST_LEVEL_UP) begin
          w_bar_speed_nx = w_speed_sat;
        end
        // timer <= 1 also covers a zero frame count loaded at entry.
        if (tick) begin
          if (r_timer <= 8'd1) begin
            w_timer_nx   = 8'd0;
            w_state_nx   = ST_PLAY;
            w_respawn_nx = 1'b1;
            w_mask_nx    = 2'd2;
          end else begin
            w_timer_nx = r_timer - 8'd1;
          end
        end
      end

      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase

    w_freeze_nx    = (w_state_nx != ST_PLAY);
    w_game_over_nx = (w_state_nx == ST_GAME_OVER);
  end

  assign level      = r_level;
  assign lives      = r_lives;
  assign bar_speed  = r_bar_speed;
  assign freeze     = r_freeze;
  assign respawn    = r_respawn;
  assign game_over  = r_game_over;
  assign best_level = r_best;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_ctrl
// Purpose  : Directed self-checking bench for game_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick;
  logic       start_btn;
  logic       hit;
  logic [9:0] player_h;
  logic [9:0] level;
  logic [2:0] lives;
  logic [3:0] bar_speed;
  logic       freeze;
  logic       respawn;
  logic       game_over;
  logic [9:0] best_level;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  game_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .start_btn  (start_btn),
    .hit        (hit),
    .player_h   (player_h),
    .level      (level),
    .lives      (lives),
    .bar_speed  (bar_speed),
    .freeze     (freeze),
    .respawn    (respawn),
    .game_over  (game_over),
    .best_level (best_level),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1; step();
      tick = 1'b0; step();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tick = 1'b0; start_btn = 1'b0; hit = 1'b0; player_h = 10'd0;
    step(); step();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (lives !== 3'd3) begin errors++; $display("FAIL reset_lives got %0d exp 3", lives); end
    checks++; if (level !== 10'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL reset_freeze got %0b exp 1", freeze); end
    checks++; if (bar_speed !== 4'd1) begin errors++; $display("FAIL reset_speed got %0d exp 1", bar_speed); end
    checks++; if (respawn !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL reset_pulses got respawn=%0b game_over=%0b exp 0 0", respawn, game_over); end
    checks++; if (best_level !== 10'd0) begin errors++; $display("FAIL reset_best got %0d exp 0", best_level); end
  endtask

  task automatic test_start();
    int pulses;
    pulses = 0;
    reset_n = 1'b1; step();
    start_btn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (respawn === 1'b1) pulses++;
    end
    start_btn = 1'b0;
    checks++; if (pulses != 1) begin errors++; $display("FAIL start_respawn_count got %0d exp 1", pulses); end
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL start_state got %0d exp 1", state); end
    checks++; if (lives !== 3'd3) begin errors++; $display("FAIL start_lives got %0d exp 3", lives); end
    checks++; if (level !== 10'd0) begin errors++; $display("FAIL start_level got %0d exp 0", level); end
    checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL start_freeze got %0b exp 0", freeze); end
    checks++; if (bar_speed !== 4'd1) begin errors++; $display("FAIL start_speed got %0d exp 1", bar_speed); end
    step();
  endtask

  task automatic test_hit();
    hit = 1'b1; step();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL hit_state got %0d exp 2", state); end
    checks++; if (lives !== 3'd2) begin errors++; $display("FAIL hit_lives got %0d exp 2", lives); end
    checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL hit_freeze got %0b exp 1", freeze); end
    step(); step();
    // hit stays high through the whole respawn delay
    checks++; if (lives !== 3'd2) begin errors++; $display("FAIL hit_held_lives got %0d exp 2", lives); end
    run_ticks(59);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL dying_59_ticks got state %0d exp 2", state); end
    tick = 1'b1; step(); tick = 1'b0;
    checks++; if (state !== 3'd1 || respawn !== 1'b1) begin errors++; $display("FAIL dying_expire got state=%0d respawn=%0b exp 1 1", state, respawn); end
    step();
    checks++; if (respawn !== 1'b0) begin errors++; $display("FAIL respawn_width got %0b exp 0", respawn); end
    checks++; if (lives !== 3'd2 || state !== 3'd1) begin errors++; $display("FAIL hit_held_after got lives=%0d state=%0d exp 2 1", lives, state); end
    hit = 1'b0; step(); step();
  endtask

  task automatic test_hit_goal_same_cycle();
    hit = 1'b1; player_h = 10'd585; step();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL hit_goal_state got %0d exp 2", state); end
    checks++; if (level !== 10'd0) begin errors++; $display("FAIL hit_goal_level got %0d exp 0", level); end
    checks++; if (lives !== 3'd1) begin errors++; $display("FAIL hit_goal_lives got %0d exp 1", lives); end
    hit = 1'b0; player_h = 10'd0;
    run_ticks(59);
    tick = 1'b1; step(); tick = 1'b0;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL hit_goal_back got state %0d exp 1", state); end
    step(); step(); step();
  endtask

  task automatic test_level_up(input int start_lvl, input int n);
    int exp_lvl;
    int exp_spd;
    for (int i = 0; i < n; i++) begin
      exp_lvl = (start_lvl + i + 1 > 15) ? 15 : start_lvl + i + 1;
      exp_spd = (1 + exp_lvl > 15) ? 15 : 1 + exp_lvl;
      player_h = 10'd585; step();
      checks++; if (state !== 3'd3 || freeze !== 1'b1) begin errors++; $display("FAIL lvl_enter[%0d] got state=%0d freeze=%0b exp 3 1", i, state, freeze); end
      checks++; if (level !== 10'(exp_lvl)) begin errors++; $display("FAIL lvl_level[%0d] got %0d exp %0d", i, level, exp_lvl); end
      step();
      checks++; if (bar_speed !== 4'(exp_spd)) begin errors++; $display("FAIL lvl_speed[%0d] got %0d exp %0d", i, bar_speed, exp_spd); end
      run_ticks(29);
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL lvl_29_ticks[%0d] got state %0d exp 3", i, state); end
      tick = 1'b1; step(); tick = 1'b0;
      checks++; if (state !== 3'd1 || respawn !== 1'b1) begin errors++; $display("FAIL lvl_expire[%0d] got state=%0d respawn=%0b exp 1 1", i, state, respawn); end
      // player still past the goal for one more cycle: must not re-trigger
      step();
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL lvl_goal_mask[%0d] got state %0d exp 1", i, state); end
      player_h = 10'd0; step();
    end
  endtask

  task automatic test_game_over();
    hit = 1'b1; step();
    checks++; if (state !== 3'd4 || game_over !== 1'b1) begin errors++; $display("FAIL go_state got state=%0d game_over=%0b exp 4 1", state, game_over); end
    checks++; if (lives !== 3'd0) begin errors++; $display("FAIL go_lives got %0d exp 0", lives); end
    checks++; if (best_level !== 10'd1) begin errors++; $display("FAIL go_best got %0d exp 1", best_level); end
    checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL go_freeze got %0b exp 1", freeze); end
    hit = 1'b0; step(); step();
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL go_hold got state %0d exp 4", state); end
    start_btn = 1'b1; step();
    checks++; if (state !== 3'd1 || respawn !== 1'b1) begin errors++; $display("FAIL go_restart got state=%0d respawn=%0b exp 1 1", state, respawn); end
    checks++; if (lives !== 3'd3 || level !== 10'd0 || bar_speed !== 4'd1) begin errors++; $display("FAIL go_reload got lives=%0d level=%0d speed=%0d exp 3 0 1", lives, level, bar_speed); end
    checks++; if (best_level !== 10'd1 || game_over !== 1'b0) begin errors++; $display("FAIL go_best_keep got best=%0d game_over=%0b exp 1 0", best_level, game_over); end
    start_btn = 1'b0; step(); step(); step();
  endtask

  task automatic test_level_saturation();
    test_level_up(0, 16);
    checks++; if (level !== 10'd15 || bar_speed !== 4'd15) begin errors++; $display("FAIL sat_final got level=%0d speed=%0d exp 15 15", level, bar_speed); end
    start_btn = 1'b1; step(); start_btn = 1'b0; step();
    checks++; if (state !== 3'd1 || level !== 10'd15 || respawn !== 1'b0) begin errors++; $display("FAIL start_in_play got state=%0d level=%0d respawn=%0b exp 1 15 0", state, level, respawn); end
  endtask

  task automatic test_async_reset();
    hit = 1'b1; step(); hit = 1'b0;
    run_ticks(10);
    checks++; if (state !== 3'd2 || lives !== 3'd2) begin errors++; $display("FAIL arst_pre got state=%0d lives=%0d exp 2 2", state, lives); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || lives !== 3'd3 || level !== 10'd0) begin errors++; $display("FAIL arst_core got state=%0d lives=%0d level=%0d exp 0 3 0", state, lives, level); end
    checks++; if (freeze !== 1'b1 || respawn !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL arst_ctrl got freeze=%0b respawn=%0b game_over=%0b exp 1 0 0", freeze, respawn, game_over); end
    checks++; if (bar_speed !== 4'd1 || best_level !== 10'd0) begin errors++; $display("FAIL arst_misc got speed=%0d best=%0d exp 1 0", bar_speed, best_level); end
    @(negedge clk); reset_n = 1'b1; step();
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog got timeout exp completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_start();
    test_hit();
    test_hit_goal_same_cycle();
    test_level_up(0, 1);
    test_game_over();
    test_level_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
